// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for the Avalon-MM slave word memory.
package avalon_mem_pkg;

    typedef enum logic [1:0] {IDLE, STALL, ACK} mem_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    // Wide enough for WAIT_CYCLES (<=15) plus the optional random extra (<=3).
    localparam int          CNT_W        = 5;

    // Word index relative to the memory base; addresses below the base wrap
    // to a huge index and therefore land out of range.
    function automatic logic [29:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[31:2];
    endfunction

endpackage

// File: rtl/wait_lfsr.sv
// 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1) that randomises the stall count.
// Only built when WAIT_RANDOM_EN is defined.
`ifdef WAIT_RANDOM_EN
module wait_lfsr (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_i,
    output logic [7:0] lfsr_o
);
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'h5A;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;
endmodule
`endif

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave word memory with programmable wait states and a preload port.
// Define WAIT_RANDOM_EN to add a pseudo-random 0..3 extra stall per transfer.
import avalon_mem_pkg::*;

module avalon_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]      mem_q [DEPTH];
    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, stall_cnt;
    logic [31:0]      rdata_q, rdata_d;
    logic             req, accept, commit;
    logic [29:0]      idx, ld_idx;
    logic             in_rng, ld_in_rng;

    assign req       = read | write;
    assign idx       = word_index(address, BASE_ADDR);
    assign ld_idx    = word_index(load_addr, BASE_ADDR);
    assign in_rng    = (idx >> ADDR_W) == '0;
    assign ld_in_rng = (ld_idx >> ADDR_W) == '0;

    // A transfer is accepted only in ACK, and neither a preload nor a reset
    // in that same cycle may let a write slip through.
    assign accept      = (state_q == ACK) && req && !load_en && !reset;
    assign commit      = accept && write && !read && in_rng;
    assign waitrequest = req && ((state_q != ACK) || load_en || reset);
    assign readdata    = rdata_q;

`ifdef WAIT_RANDOM_EN
    logic [7:0] lfsr;
    wait_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .step_i (accept),
        .lfsr_o (lfsr)
    );
    assign stall_cnt = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr[1:0]);
`else
    assign stall_cnt = CNT_W'(WAIT_CYCLES);
`endif

    always_comb begin
        logic go_ack;
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        go_ack  = 1'b0;
        if (load_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    cnt_d = stall_cnt;
                    if (stall_cnt == '0) begin
                        state_d = ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end
                STALL: begin
                    if (!req) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = ACK;
                        go_ack  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Read data is captured on the way into ACK so it is stable there.
        if (go_ack && read)
            rdata_d = in_rng ? mem_q[idx[ADDR_W-1:0]] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Contents survive reset; preload wins over a bus write.
    always_ff @(posedge clk) begin
        if (load_en) begin
            if (ld_in_rng)
                mem_q[ld_idx[ADDR_W-1:0]] <= load_data;
        end else if (commit) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b])
                    mem_q[idx[ADDR_W-1:0]][8*b +: 8] <= writedata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Self-checking bench for avalon_slave_mem: directed table, corner sequences,
// and randomized transfers against an array-based reference memory.
module tb_avalon_slave_mem;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          AW    = 10;
    localparam int          W     = 1;
    localparam int          DEPTH = 1 << AW;

    logic        clk, reset;
    logic [31:0] address, writedata, readdata, load_addr, load_data;
    logic        read, write, waitrequest, load_en;
    logic [3:0]  byteenable;

    avalon_slave_mem #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_waits(input string name, input int w);
        bit ok;
        tests++;
`ifdef WAIT_RANDOM_EN
        ok = (w >= W + 1) && (w <= W + 4);
`else
        ok = (w == W + 1);
`endif
        if (!ok) begin
            fails++;
            $display("FAIL %s: waitrequest high %0d cycles, expected %0d", name, w, W + 1);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        if (a < BASE) return 1'b0;
        return ((a - BASE) / 4) < DEPTH;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        if (m_in(a))
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        if (m_in(a)) ref_mem[m_idx(a)] = d;
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int waits, output logic [31:0] rdata);
        read = rd; write = wr; address = a; byteenable = be; writedata = d;
        waits = 0;
        rdata = 32'hx;
        while (1) begin
            #1;
            if (!waitrequest) begin
                rdata = readdata;
                break;
            end
            waits++;
            if (waits > 40) break;
            tick();
        end
        tick();
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        int          w;
        logic [31:0] rd;

        tbl[0]  = '{0, 1, 32'hBFC00010, 4'hF, 32'h11223344, 32'h0};
        tbl[1]  = '{0, 1, 32'hBFC00010, 4'h5, 32'hAABBCCDD, 32'h0};
        tbl[2]  = '{1, 0, 32'hBFC00010, 4'h0, 32'h0,        32'h11BB33DD};
        tbl[3]  = '{0, 1, 32'h00001000, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1, 0, 32'h00001000, 4'h0, 32'h0,        32'h0};
        tbl[5]  = '{1, 0, 32'hBFC01000, 4'h0, 32'h0,        32'h0};
        tbl[6]  = '{0, 1, 32'hBFC00FFC, 4'hF, 32'h12345678, 32'h0};
        tbl[7]  = '{1, 0, 32'hBFC00FFC, 4'h0, 32'h0,        32'h12345678};
        tbl[8]  = '{0, 1, 32'hBFC00010, 4'h0, 32'hFFFFFFFF, 32'h0};
        tbl[9]  = '{1, 0, 32'hBFC00010, 4'h0, 32'h0,        32'h11BB33DD};
        tbl[10] = '{1, 1, 32'hBFC00010, 4'hF, 32'h0,        32'h11BB33DD};
        tbl[11] = '{1, 0, 32'hBFC00010, 4'h0, 32'h0,        32'h11BB33DD};
        tbl[12] = '{1, 0, 32'hBFC00023, 4'h0, 32'h0,        32'hC0DE0008};

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; byteenable = '0;
        writedata = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        #1;
        check("reset_waitreq_idle", {31'b0, waitrequest}, 32'h0);
        check("reset_rdata", readdata, 32'h0);
        tick();
        read = 1'b1;
        #1;
        check("reset_waitreq_req", {31'b0, waitrequest}, 32'h1);
        tick();
        read = 1'b0; reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) preload(BASE + 32'(4 * i), 32'hC0DE0000 | 32'(i));

        // Preloaded reset-vector word, then a read of it.
        preload(32'hBFC00000, 32'h2404FEDC);
        xfer(1, 0, 32'hBFC00000, 4'h0, 32'h0, w, rd);
        chk_waits("t1_waits", w);
        check("t1_rdata", rd, 32'h2404FEDC);

        for (int i = 0; i < 13; i++) begin
            xfer(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, w, rd);
            chk_waits($sformatf("vec%0d_waits", i), w);
            if (tbl[i].rd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
            else model_write(tbl[i].addr, tbl[i].be, tbl[i].wdata);
        end

        // Reset in STALL kills the pending write.
        preload(32'hBFC00040, 32'h0);
        write = 1'b1; address = 32'hBFC00040; byteenable = 4'hF; writedata = 32'hFFFFFFFF;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; write = 1'b0;
        #1;
        check("t4_rdata_after_reset", readdata, 32'h0);
        tick();
        xfer(1, 0, 32'hBFC00040, 4'h0, 32'h0, w, rd);
        check("t4_rdata", rd, 32'h0);

`ifndef WAIT_RANDOM_EN
        // Reset in ACK also kills the write.
        preload(32'hBFC00050, 32'h0);
        write = 1'b1; address = 32'hBFC00050; byteenable = 4'hF; writedata = 32'hFFFFFFFF;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("ack_reset_waitreq", {31'b0, waitrequest}, 32'h1);
        tick();
        reset = 1'b0; write = 1'b0;
        xfer(1, 0, 32'hBFC00050, 4'h0, 32'h0, w, rd);
        check("ack_reset_rdata", rd, 32'h0);
`endif

        // Request withdrawn during STALL: no commit.
        write = 1'b1; address = 32'hBFC00060; byteenable = 4'hF; writedata = 32'h0;
        tick();
        write = 1'b0;
        tick(); tick();
        xfer(1, 0, 32'hBFC00060, 4'h0, 32'h0, w, rd);
        check("withdraw_rdata", rd, 32'hC0DE0018);

        // Preload holds off a pending read.
        read = 1'b1; address = 32'hBFC00084;
        load_en = 1'b1; load_addr = 32'hBFC00080; load_data = 32'h55AA55AA;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t5_waitreq_%0d", k), {31'b0, waitrequest}, 32'h1);
            tick();
        end
        load_en = 1'b0;
        ref_mem[32] = 32'h55AA55AA;
        xfer(1, 0, 32'hBFC00084, 4'h0, 32'h0, w, rd);
        chk_waits("t5_waits", w);
        check("t5_rdata", rd, 32'hC0DE0021);
        xfer(1, 0, 32'hBFC00080, 4'h0, 32'h0, w, rd);
        check("t5_preload_rdata", rd, 32'h55AA55AA);

        for (int n = 0; n < 300; n++) begin
            int          kind, mode;
            logic [31:0] a, d, exp;
            logic [3:0]  be;
            kind = $urandom_range(0, 9);
            if (kind < 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (kind == 8) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
            else a = $urandom() & 32'h7FFFFFFF;
            d  = $urandom();
            be = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                preload(a, d);
            end else begin
                bit r, wr_;
                r   = (mode <= 4) || (mode == 9);
                wr_ = (mode >= 5);
                exp = m_in(a) ? ref_mem[m_idx(a)] : 32'h0;
                xfer(r, wr_, a, be, d, w, rd);
                chk_waits($sformatf("rnd%0d_waits", n), w);
                if (r) check($sformatf("rnd%0d_rdata", n), rd, exp);
                else model_write(a, be, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
